// File: rtl/interconnect_pkg.sv
// Shared types and helpers for the read/write interconnect blocks.
//   ar_t / r_t    : AR and R channel payloads at the default geometry
//                   (32-bit address, 64-bit data, 6-bit subordinate-side ID).
//   RESP_*        : AXI response encodings used by the crossbars.
//   mi_width()    : width of the manager-index prefix added to IDs.
package interconnect_pkg;

  localparam int unsigned PkgAddrWidth = 32;
  localparam int unsigned PkgDataWidth = 64;
  localparam int unsigned PkgSidWidth  = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [PkgAddrWidth-1:0] addr;
    logic [PkgSidWidth-1:0]  id;
    logic [7:0]              len;
  } ar_t;

  typedef struct packed {
    logic [PkgDataWidth-1:0] data;
    logic [PkgSidWidth-1:0]  id;
    logic [1:0]              resp;
    logic                    last;
  } r_t;

  // At least one prefix bit so a single-manager build still has a legal field.
  function automatic int unsigned mi_width(int unsigned n_m);
    return (n_m > 2) ? $clog2(n_m) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter with grant lock.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : N request lines
//   lock_i       : replay last cycle's grant instead of re-arbitrating
//   advance_i    : move the priority pointer past the current winner
//   gnt_o        : one-hot grant (all zero when nothing requests)
module rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         lock_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  rr_gnt;
  logic [PW-1:0] idx;
  logic          found;
  int            tmp;
  int            cur;

  always_comb begin
    rr_gnt = '0;
    found  = 1'b0;
    idx    = '0;
    tmp    = 0;
    // Scan from the pointer, wrapping once, first requester wins.
    for (int k = 0; k < int'(N); k++) begin
      tmp = int'(ptr_q) + k;
      if (tmp >= int'(N)) tmp = tmp - int'(N);
      idx = PW'(tmp);
      if (!found && req_i[idx]) begin
        rr_gnt[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    gnt_o = lock_i ? gnt_q : rr_gnt;
    gnt_d = gnt_o;
    cur   = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_o[i]) cur = i;
    end
    ptr_d = ptr_q;
    if (advance_i) ptr_d = (cur + 1 >= int'(N)) ? '0 : PW'(cur + 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      gnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
    end
  end

endmodule

// File: rtl/axi_rd_xbar.sv
// AXI4 read-path crossbar (AR + R) between N_M managers and N_S subordinates.
//   m_ar*  : manager AR inputs, m_arready_o back
//   m_r*   : R responses to managers, ID prefix stripped
//   s_ar*  : AR to subordinates, ID = {manager index, manager ID}
//   s_r*   : R from subordinates, routed back by the ID prefix
// Unmapped addresses go to an internal DECERR responder (target index N_S).
// A manager may only have outstanding reads to one target at a time.
module axi_rd_xbar
  import interconnect_pkg::*;
#(
  parameter int unsigned N_M             = 4,
  parameter int unsigned N_S             = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  // Entries listed left to right: the leftmost is subordinate 0.
  parameter logic [N_S*ADDR_WIDTH-1:0] S_BASE = {32'h8000_0000, 32'h1000_0000},
  parameter logic [N_S*ADDR_WIDTH-1:0] S_MASK = {32'hC000_0000, 32'hF000_0000},
  localparam int unsigned MI_W  = mi_width(N_M),
  localparam int unsigned SID_W = ID_WIDTH + MI_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_M-1:0]            m_arvalid_i,
  output logic [N_M-1:0]            m_arready_o,
  input  logic [N_M*ADDR_WIDTH-1:0] m_araddr_i,
  input  logic [N_M*ID_WIDTH-1:0]   m_arid_i,
  input  logic [N_M*8-1:0]          m_arlen_i,
  output logic [N_M-1:0]            m_rvalid_o,
  input  logic [N_M-1:0]            m_rready_i,
  output logic [N_M*DATA_WIDTH-1:0] m_rdata_o,
  output logic [N_M*ID_WIDTH-1:0]   m_rid_o,
  output logic [N_M*2-1:0]          m_rresp_o,
  output logic [N_M-1:0]            m_rlast_o,
  output logic [N_S-1:0]            s_arvalid_o,
  input  logic [N_S-1:0]            s_arready_i,
  output logic [N_S*ADDR_WIDTH-1:0] s_araddr_o,
  output logic [N_S*SID_W-1:0]      s_arid_o,
  output logic [N_S*8-1:0]          s_arlen_o,
  input  logic [N_S-1:0]            s_rvalid_i,
  output logic [N_S-1:0]            s_rready_o,
  input  logic [N_S*DATA_WIDTH-1:0] s_rdata_i,
  input  logic [N_S*SID_W-1:0]      s_rid_i,
  input  logic [N_S*2-1:0]          s_rresp_i,
  input  logic [N_S-1:0]            s_rlast_i
);

  localparam int unsigned NT = N_S + 1;
  localparam int unsigned TW = $clog2(N_S + 1);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [0:0]  StIdle = 1'b0;
  localparam logic [0:0]  StResp = 1'b1;

  logic [TW-1:0]   tgt        [N_M];
  logic [N_M-1:0]  elig;
  logic [CW-1:0]   cnt_q      [N_M];
  logic [CW-1:0]   cnt_d      [N_M];
  logic [TW-1:0]   last_tgt_q [N_M];
  logic [TW-1:0]   last_tgt_d [N_M];

  logic [N_M-1:0]  ar_req [NT];
  logic [N_M-1:0]  ar_gnt [NT];
  logic [N_M-1:0]  ar_win [NT];
  logic [NT-1:0]   t_arvalid, t_arready, ar_adv, ar_lock_q, ar_lock_d;

  logic [MI_W-1:0] s_pref [N_S];
  logic [NT-1:0]   r_req  [N_M];
  logic [NT-1:0]   r_gnt  [N_M];
  logic [NT-1:0]   r_win  [N_M];
  logic [N_M-1:0]  r_adv, r_lock_q, r_lock_d;

  logic [0:0]          dec_st_q, dec_st_d;
  logic [ID_WIDTH-1:0] dec_id_q, dec_id_d;
  logic [7:0]          dec_len_q, dec_len_d, dec_beat_q, dec_beat_d;
  logic [MI_W-1:0]     dec_mgr_q, dec_mgr_d;
  logic                dec_last, dec_hs;

  // Address decode (lowest matching window wins) and the ordering gate.
  always_comb begin
    for (int m = 0; m < int'(N_M); m++) begin
      tgt[m] = TW'(N_S);
      for (int s = int'(N_S) - 1; s >= 0; s--) begin
        if ((m_araddr_i[m*ADDR_WIDTH +: ADDR_WIDTH] &
             S_MASK[(int'(N_S)-1-s)*ADDR_WIDTH +: ADDR_WIDTH]) ==
            S_BASE[(int'(N_S)-1-s)*ADDR_WIDTH +: ADDR_WIDTH]) tgt[m] = TW'(s);
      end
      elig[m] = (cnt_q[m] == '0) ||
                ((cnt_q[m] < CW'(MAX_OUTSTANDING)) && (tgt[m] == last_tgt_q[m]));
      for (int t = 0; t < int'(NT); t++) begin
        ar_req[t][m] = m_arvalid_i[m] & elig[m] & (tgt[m] == TW'(t));
      end
    end
  end

  for (genvar t = 0; t < int'(NT); t++) begin : g_ar_arb
    rr_arb #(.N(N_M)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (ar_req[t]),
      .lock_i    (ar_lock_q[t]),
      .advance_i (ar_adv[t]),
      .gnt_o     (ar_gnt[t])
    );
  end

  always_comb begin
    m_arready_o = '0;
    s_araddr_o  = '0;
    s_arid_o    = '0;
    s_arlen_o   = '0;
    for (int t = 0; t < int'(N_S); t++) t_arready[t] = s_arready_i[t];
    t_arready[N_S] = (dec_st_q == StIdle);
    for (int t = 0; t < int'(NT); t++) begin
      ar_win[t]    = ar_gnt[t] & ar_req[t];
      t_arvalid[t] = |ar_win[t];
      // Hold the grant while valid waits for ready so the payload stays stable.
      ar_lock_d[t] = t_arvalid[t] & ~t_arready[t];
      ar_adv[t]    = t_arvalid[t] & t_arready[t];
      for (int m = 0; m < int'(N_M); m++) begin
        m_arready_o[m] = m_arready_o[m] | (ar_win[t][m] & t_arready[t]);
      end
    end
    s_arvalid_o = t_arvalid[N_S-1:0];
    for (int s = 0; s < int'(N_S); s++) begin
      for (int m = 0; m < int'(N_M); m++) begin
        if (ar_win[s][m]) begin
          s_araddr_o[s*ADDR_WIDTH +: ADDR_WIDTH] = m_araddr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
          s_arid_o[s*SID_W +: SID_W] = {MI_W'(m), m_arid_i[m*ID_WIDTH +: ID_WIDTH]};
          s_arlen_o[s*8 +: 8] = m_arlen_i[m*8 +: 8];
        end
      end
    end
  end

  // R routing: per manager, pick among subordinates carrying its prefix plus DECERR.
  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_rid_o    = '0;
    m_rresp_o  = {N_M{RESP_OKAY}};
    m_rlast_o  = '0;
    s_rready_o = '0;
    dec_hs     = 1'b0;
    for (int s = 0; s < int'(N_S); s++) s_pref[s] = s_rid_i[s*SID_W + ID_WIDTH +: MI_W];
    for (int m = 0; m < int'(N_M); m++) begin
      for (int s = 0; s < int'(N_S); s++) begin
        r_req[m][s] = s_rvalid_i[s] & (s_pref[s] == MI_W'(m));
      end
      r_req[m][N_S] = (dec_st_q == StResp) & (dec_mgr_q == MI_W'(m));
      r_win[m]      = r_gnt[m] & r_req[m];
      m_rvalid_o[m] = |r_win[m];
      for (int s = 0; s < int'(N_S); s++) begin
        if (r_win[m][s]) begin
          m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
          m_rid_o[m*ID_WIDTH +: ID_WIDTH]       = s_rid_i[s*SID_W +: ID_WIDTH];
          m_rresp_o[m*2 +: 2]                   = s_rresp_i[s*2 +: 2];
          m_rlast_o[m]                          = s_rlast_i[s];
          s_rready_o[s]                         = m_rready_i[m];
        end
      end
      if (r_win[m][N_S]) begin
        m_rid_o[m*ID_WIDTH +: ID_WIDTH] = dec_id_q;
        m_rresp_o[m*2 +: 2]             = RESP_DECERR;
        m_rlast_o[m]                    = dec_last;
        dec_hs                          = m_rready_i[m];
      end
      // Lock from first presented beat until the rlast handshake: no interleave,
      // and a stalled beat never switches source.
      r_adv[m]    = m_rvalid_o[m] & m_rready_i[m] & m_rlast_o[m];
      r_lock_d[m] = m_rvalid_o[m] & ~r_adv[m];
    end
    // Responses whose prefix names no manager are sunk.
    for (int s = 0; s < int'(N_S); s++) begin
      if (s_rvalid_i[s] && (int'(s_pref[s]) >= int'(N_M))) s_rready_o[s] = 1'b1;
    end
  end

  for (genvar m = 0; m < int'(N_M); m++) begin : g_r_arb
    rr_arb #(.N(NT)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (r_req[m]),
      .lock_i    (r_lock_q[m]),
      .advance_i (r_adv[m]),
      .gnt_o     (r_gnt[m])
    );
  end

  // Outstanding counters; simultaneous inc and dec cancel.
  always_comb begin
    for (int m = 0; m < int'(N_M); m++) begin
      cnt_d[m]      = cnt_q[m];
      last_tgt_d[m] = last_tgt_q[m];
      if (m_arvalid_i[m] && m_arready_o[m]) begin
        last_tgt_d[m] = tgt[m];
        if (!r_adv[m]) cnt_d[m] = cnt_q[m] + 1'b1;
      end else if (r_adv[m] && (cnt_q[m] != '0)) begin
        cnt_d[m] = cnt_q[m] - 1'b1;
      end
    end
  end

  // DECERR responder: one burst at a time.
  assign dec_last = (dec_beat_q == dec_len_q);

  always_comb begin
    dec_st_d   = dec_st_q;
    dec_id_d   = dec_id_q;
    dec_len_d  = dec_len_q;
    dec_beat_d = dec_beat_q;
    dec_mgr_d  = dec_mgr_q;
    case (dec_st_q)
      StIdle: begin
        if (ar_adv[N_S]) begin
          dec_st_d   = StResp;
          dec_beat_d = '0;
          for (int m = 0; m < int'(N_M); m++) begin
            if (ar_win[N_S][m]) begin
              dec_mgr_d = MI_W'(m);
              dec_id_d  = m_arid_i[m*ID_WIDTH +: ID_WIDTH];
              dec_len_d = m_arlen_i[m*8 +: 8];
            end
          end
        end
      end
      StResp: begin
        if (dec_hs) begin
          if (dec_last) dec_st_d = StIdle;
          else          dec_beat_d = dec_beat_q + 8'd1;
        end
      end
      default: dec_st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int m = 0; m < int'(N_M); m++) begin
        cnt_q[m]      <= '0;
        last_tgt_q[m] <= '0;
      end
      ar_lock_q  <= '0;
      r_lock_q   <= '0;
      dec_st_q   <= StIdle;
      dec_id_q   <= '0;
      dec_len_q  <= '0;
      dec_beat_q <= '0;
      dec_mgr_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_tgt_q <= last_tgt_d;
      ar_lock_q  <= ar_lock_d;
      r_lock_q   <= r_lock_d;
      dec_st_q   <= dec_st_d;
      dec_id_q   <= dec_id_d;
      dec_len_q  <= dec_len_d;
      dec_beat_q <= dec_beat_d;
      dec_mgr_q  <= dec_mgr_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_xbar.sv
// Scoreboard bench for axi_rd_xbar: stimulus pushes expected subordinate ARs and
// manager R beats; negedge monitors pop and compare on every handshake.
module tb_axi_rd_xbar;

  localparam int NM = 4;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = 6;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [NM-1:0]    m_arvalid_i, m_arready_o, m_rvalid_o, m_rready_i, m_rlast_o;
  logic [NM*AW-1:0] m_araddr_i;
  logic [NM*IW-1:0] m_arid_i, m_rid_o;
  logic [NM*8-1:0]  m_arlen_i;
  logic [NM*DW-1:0] m_rdata_o;
  logic [NM*2-1:0]  m_rresp_o;
  logic [NS-1:0]    s_arvalid_o, s_arready_i, s_rvalid_i, s_rready_o, s_rlast_i;
  logic [NS*AW-1:0] s_araddr_o;
  logic [NS*SW-1:0] s_arid_o, s_rid_i;
  logic [NS*8-1:0]  s_arlen_o;
  logic [NS*DW-1:0] s_rdata_i;
  logic [NS*2-1:0]  s_rresp_i;

  axi_rd_xbar #(
    .N_M(NM), .N_S(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(8)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o), .m_araddr_i(m_araddr_i),
    .m_arid_i(m_arid_i), .m_arlen_i(m_arlen_i),
    .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i), .m_rdata_o(m_rdata_o),
    .m_rid_o(m_rid_o), .m_rresp_o(m_rresp_o), .m_rlast_o(m_rlast_o),
    .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i), .s_araddr_o(s_araddr_o),
    .s_arid_o(s_arid_o), .s_arlen_o(s_arlen_o),
    .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o), .s_rdata_i(s_rdata_i),
    .s_rid_i(s_rid_i), .s_rresp_i(s_rresp_i), .s_rlast_i(s_rlast_i)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] id;
    logic [7:0]    len;
  } sar_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } rb_t;

  sar_t exp_sar [NS][$];
  rb_t  exp_r   [NM][$];
  sar_t mon_sar;
  rb_t  mon_r;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic int pending();
    int n = 0;
    for (int s = 0; s < NS; s++) n += exp_sar[s].size();
    for (int m = 0; m < NM; m++) n += exp_r[m].size();
    return n;
  endfunction

  // Monitors
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int s = 0; s < NS; s++) begin
        if (s_arvalid_o[s] && s_arready_i[s]) begin
          mon_sar = {s_araddr_o[s*AW +: AW], s_arid_o[s*SW +: SW], s_arlen_o[s*8 +: 8]};
          if (exp_sar[s].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL s_ar_unexpected: s%0d got 0x%0h, expected no request", s, mon_sar);
          end else begin
            chk($sformatf("s%0d_ar", s), mon_sar, exp_sar[s].pop_front());
          end
        end
      end
      for (int m = 0; m < NM; m++) begin
        if (m_rvalid_o[m] && m_rready_i[m]) begin
          mon_r = {m_rdata_o[m*DW +: DW], m_rid_o[m*IW +: IW], m_rresp_o[m*2 +: 2], m_rlast_o[m]};
          if (exp_r[m].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL m_r_unexpected: m%0d got 0x%0h, expected no beat", m, mon_r);
          end else begin
            chk($sformatf("m%0d_r", m), mon_r, exp_r[m].pop_front());
          end
        end
      end
    end
  end

  task automatic exp_ar(input int s, input logic [AW-1:0] a, input logic [SW-1:0] id,
                        input logic [7:0] len);
    exp_sar[s].push_back({a, id, len});
  endtask

  task automatic exp_beat(input int m, input logic [DW-1:0] d, input logic [IW-1:0] id,
                          input logic [1:0] resp, input logic last);
    exp_r[m].push_back({d, id, resp, last});
  endtask

  task automatic ar_issue(input int m, input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input logic [7:0] len);
    int n = 0;
    m_araddr_i[m*AW +: AW] = a;
    m_arid_i[m*IW +: IW]   = id;
    m_arlen_i[m*8 +: 8]    = len;
    m_arvalid_i[m]         = 1'b1;
    forever begin
      @(negedge clk_i);
      if (m_arready_o[m]) break;
      n++;
      if (n > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL ar_timeout: m%0d got no arready, expected handshake", m);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    m_arvalid_i[m] = 1'b0;
  endtask

  task automatic s_burst(input int s, input logic [SW-1:0] sid, input logic [DW-1:0] base,
                         input int nb);
    for (int b = 0; b < nb; b++) begin
      int n = 0;
      s_rvalid_i[s]           = 1'b1;
      s_rid_i[s*SW +: SW]     = sid;
      s_rdata_i[s*DW +: DW]   = base + DW'(b);
      s_rresp_i[s*2 +: 2]     = 2'b00;
      s_rlast_i[s]            = (b == nb - 1);
      forever begin
        @(negedge clk_i);
        if (s_rready_o[s]) break;
        n++;
        if (n > 200) begin
          n_chk++;
          n_fail++;
          $display("FAIL r_timeout: s%0d got no rready, expected handshake", s);
          break;
        end
      end
      @(posedge clk_i);
      #1;
    end
    s_rvalid_i[s] = 1'b0;
    s_rlast_i[s]  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (pending() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_pending", pending(), 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1);
  end

  initial begin
    m_arvalid_i = '0; m_araddr_i = '0; m_arid_i = '0; m_arlen_i = '0; m_rready_i = '1;
    s_arready_i = '1; s_rvalid_i = '0; s_rdata_i = '0; s_rid_i = '0; s_rresp_i = '0;
    s_rlast_i = '0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_m_arready", m_arready_o, 0);
    chk("rst_s_arvalid", s_arvalid_o, 0);
    chk("rst_m_rvalid", m_rvalid_o, 0);
    chk("rst_s_rready", s_rready_o, 0);
    chk("rst_s_araddr", s_araddr_o, 0);
    chk("rst_m_rdata", m_rdata_o, 0);
    @(posedge clk_i);
    #1;

    // Basic burst: M0 -> s0, 4 beats back.
    exp_ar(0, 32'h8000_0040, 6'h05, 8'd3);
    for (int b = 0; b < 4; b++) exp_beat(0, 64'hA0 + 64'(b), 4'h5, 2'b00, b == 3);
    ar_issue(0, 32'h8000_0040, 4'h5, 8'd3);
    s_burst(0, 6'h05, 64'hA0, 4);
    wait_drain();

    // Ordering gate: M0 busy on s0 cannot start an AR to s1.
    exp_ar(0, 32'h8000_0100, 6'h01, 8'd0);
    ar_issue(0, 32'h8000_0100, 4'h1, 8'd0);
    exp_ar(1, 32'h1000_0010, 6'h02, 8'd0);
    exp_beat(0, 64'hB0, 4'h1, 2'b00, 1'b1);
    fork
      ar_issue(0, 32'h1000_0010, 4'h2, 8'd0);
      begin
        repeat (3) begin
          @(negedge clk_i);
          chk("gate_m0_arready", m_arready_o[0], 0);
          chk("gate_s1_arvalid", s_arvalid_o[1], 0);
        end
        @(posedge clk_i);
        #1;
        s_burst(0, 6'h01, 64'hB0, 1);
      end
    join
    exp_beat(0, 64'hC0, 4'h2, 2'b00, 1'b1);
    s_burst(1, 6'h02, 64'hC0, 1);
    wait_drain();

    // Contention: M1 and M2 to s1 in the same cycle.
    exp_ar(1, 32'h1000_0000, 6'h13, 8'd0);
    exp_ar(1, 32'h1000_0020, 6'h24, 8'd0);
    fork
      ar_issue(1, 32'h1000_0000, 4'h3, 8'd0);
      ar_issue(2, 32'h1000_0020, 4'h4, 8'd0);
      begin
        @(negedge clk_i);
        chk("rr_first_m1", m_arready_o, 4'b0010);
        @(negedge clk_i);
        chk("rr_next_m2", m_arready_o, 4'b0100);
      end
    join
    exp_beat(1, 64'hD0, 4'h3, 2'b00, 1'b1);
    exp_beat(2, 64'hE0, 4'h4, 2'b00, 1'b1);
    s_burst(1, 6'h13, 64'hD0, 1);
    s_burst(1, 6'h24, 64'hE0, 1);
    wait_drain();

    // Unmapped address from M3: DECERR burst of 2, nothing reaches a subordinate.
    exp_beat(3, 64'h0, 4'hA, 2'b11, 1'b0);
    exp_beat(3, 64'h0, 4'hA, 2'b11, 1'b1);
    fork
      ar_issue(3, 32'h4000_0000, 4'hA, 8'd1);
      begin
        @(negedge clk_i);
        chk("decerr_no_s_arvalid", s_arvalid_o, 0);
        chk("decerr_arready", m_arready_o, 4'b1000);
      end
    join
    wait_drain();

    // Both subordinates answer M0 at once; s0 wins and the burst is not interleaved.
    exp_ar(0, 32'h8000_0200, 6'h06, 8'd1);
    exp_ar(0, 32'h8000_0300, 6'h07, 8'd1);
    ar_issue(0, 32'h8000_0200, 4'h6, 8'd1);
    ar_issue(0, 32'h8000_0300, 4'h7, 8'd1);
    exp_beat(0, 64'h1000, 4'h6, 2'b00, 1'b0);
    exp_beat(0, 64'h1001, 4'h6, 2'b00, 1'b1);
    exp_beat(0, 64'h2000, 4'h7, 2'b00, 1'b0);
    exp_beat(0, 64'h2001, 4'h7, 2'b00, 1'b1);
    m_rready_i[0] = 1'b0;
    fork
      s_burst(0, 6'h06, 64'h1000, 2);
      s_burst(1, 6'h07, 64'h2000, 2);
      begin
        repeat (3) begin
          @(negedge clk_i);
          chk("stall_rvalid", m_rvalid_o[0], 1);
          chk("stall_rdata", m_rdata_o[63:0], 64'h1000);
        end
        @(posedge clk_i);
        #1;
        m_rready_i[0] = 1'b1;
      end
    join
    wait_drain();

    // Outstanding limit: 8 ARs accepted, the 9th waits for one rlast.
    for (int i = 0; i < 8; i++) begin
      exp_ar(0, 32'h8000_1000 + 32'(i * 16), {2'b00, 4'(i)}, 8'd0);
      ar_issue(0, 32'h8000_1000 + 32'(i * 16), 4'(i), 8'd0);
    end
    exp_ar(0, 32'h8000_2000, 6'h09, 8'd0);
    exp_beat(0, 64'h3000, 4'h0, 2'b00, 1'b1);
    fork
      ar_issue(0, 32'h8000_2000, 4'h9, 8'd0);
      begin
        repeat (3) begin
          @(negedge clk_i);
          chk("limit_m0_arready", m_arready_o[0], 0);
        end
        @(posedge clk_i);
        #1;
        s_burst(0, 6'h00, 64'h3000, 1);
      end
    join
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
